mc_seq: RTL and testbench
=========================

Name: mc_seq

Overview:
- Multi-cycle instruction sequencer for the RV32I datapath.
- Steps each instruction through IF/ID/EX/MEM/WB and gates the architectural write enables (PC, IR, register file, data memory) so that the combinational ctrl decoder's outputs take effect only in the correct cycle.
- Handles variable-latency instruction/data memory through a ready handshake, with a timeout.
- Counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for imem_ready/dmem_ready before trapping (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  7  opcode from IR (valid from ID onward).
- Funct3  in  3  funct3 from IR.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- ImemReq  out  1  instruction fetch request.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC from NPC.
- RegWriteEn  out  1  register file write strobe; ANDed with decoder RegWrite outside.
- MemReadEn  out  1  data read request.
- MemWriteEn  out  1  data write request.
- state  out  3  current state code.
- trap  out  1  sticky fault indicator.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encodings:
  - S_IDLE 000
  - S_IF 001
  - S_ID 010
  - S_EX 011
  - S_MEM 100
  - S_WB 101
  - S_TRAP 110
- Reset (async, any state, mid-access included):
  - state=S_IDLE, all strobes 0, trap=0, trap_cause=00, instret=0, timeout counter=0, latched class=NONE.
- S_IDLE: one cycle after reset release, go to S_IF.
- S_IF:
  - ImemReq=1.
  - On imem_ready: IRWrite=1 that cycle, go to S_ID.
  - Otherwise wait; the timeout counter increments.
  - Timeout counter reaching MEM_TIMEOUT without ready: go to S_TRAP, cause 10.
- S_ID:
  - Classify Op into a latched class: ALU (0110011, 0010011, 0110111), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111 with Funct3=000).
  - Any other pattern: go to S_TRAP, cause 01.
  - Otherwise go to S_EX.
- S_EX:
  - BRANCH: PCWrite=1 (NPC selects taken or +4 externally), retire, go to S_IF.
  - LOAD/STORE: go to S_MEM.
  - ALU/JAL/JALR: go to S_WB.
- S_MEM:
  - LOAD holds MemReadEn=1; STORE holds MemWriteEn=1, until dmem_ready.
  - On ready with LOAD: go to S_WB.
  - On ready with STORE: PCWrite=1, retire, go to S_IF.
  - Timeout: go to S_TRAP, cause 11; strobes drop in S_TRAP.
- S_WB: RegWriteEn=1, PCWrite=1, retire, go to S_IF.
- S_TRAP:
  - All strobes 0, trap=1, trap_cause held.
  - Exit only by rst.
- Timeout counter:
  - Cleared on every state change.
  - Counts only in S_IF and S_MEM while ready is low.
  - Saturates; never wraps.
- Ready in the first cycle of a wait state: accepted with zero wait.
  - Minimum CPI: ALU 4, load 5, store 4, branch 3.
- Ready arriving in a non-wait state: ignored.
- instret:
  - Increments by 1 on each retire cycle (the cycle where PCWrite=1).
  - Wraps modulo 2^CNT_W.
  - Never increments in S_TRAP.
- Strobes are Moore outputs: decoded from the state register plus the latched class, and from ready only where stated (IRWrite, and the S_MEM exit).
- Strobes are mutually consistent: at most one of MemReadEn/MemWriteEn high; IRWrite never with PCWrite.

Decomposition:
- Package mc_seq_pkg (or an include alongside ctrl_encode_def.v) holds:
  - the state codes;
  - the class codes;
  - the opcode constants shared with ctrl;
  - the trap_cause codes.
- One natural sub-module: mc_wait_timer, the MEM_TIMEOUT counter with clear/enable/expired.
- Classification and FSM stay in mc_seq.

Test Plan:
- Reset mid-S_MEM store with MemWriteEn=1, assert rst:
  - MemWriteEn drops asynchronously; state=000, instret=0.
  - After release: 000 for 1 cycle, then 001.
- ADD (Op=0110011) with imem_ready and dmem_ready tied 1:
  - Sequence IF, ID, EX, WB; IRWrite in IF; RegWriteEn+PCWrite in WB.
  - instret=1 after 4 cycles (plus the idle cycle).
- LW with dmem_ready delayed 3 cycles:
  - MemReadEn high for exactly 4 cycles, then WB.
  - Total 8 cycles; instret +1.
- BEQ followed by SW, all ready immediate:
  - BEQ retires in EX (3 cycles), SW retires in MEM (4 cycles), MemWriteEn 1 cycle.
  - instret=2.
- Op=1111111 fetched:
  - S_TRAP after ID; trap=1, cause=01.
  - All strobes 0 for 50 further cycles; instret unchanged.
- MEM_TIMEOUT=16, imem_ready held 0:
  - Trap with cause=10 exactly 16 cycles after entering S_IF.
  - Repeat with dmem_ready held 0 on LW: cause=11.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared codes for the multi-cycle RV32I sequencer: states, instruction classes,
// opcodes (common with the ctrl decoder), trap causes and the ID-stage classifier.
// Pure definitions; no latency, no backpressure.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_IF   = 3'b001,
    S_ID   = 3'b010,
    S_EX   = 3'b011,
    S_MEM  = 3'b100,
    S_WB   = 3'b101,
    S_TRAP = 3'b110
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_ALU    = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JAL    = 3'd5,
    C_JALR   = 3'd6
  } cls_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_IMEM    = 2'b10,
    TC_DMEM    = 2'b11
  } cause_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // C_NONE means the opcode (or JALR funct3) is not supported -> illegal trap.
  function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3);
    cls_t c;
    c = C_NONE;
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LUI: c = C_ALU;
      OP_LOAD:   c = C_LOAD;
      OP_STORE:  c = C_STORE;
      OP_BRANCH: c = C_BRANCH;
      OP_JAL:    c = C_JAL;
      OP_JALR:   c = (f3 == 3'b000) ? C_JALR : C_NONE;
      default:   c = C_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_seq_if.sv
// Bundle of IR fields, memory ready inputs and write-enable/status outputs of the sequencer.
// No latency (wires only); memory backpressure is carried by imem_ready/dmem_ready.
// master = sequencer side, slave = datapath/memory side.
interface mc_seq_if #(parameter int CNT_W = 32);
  logic [6:0]       Op;
  logic [2:0]       Funct3;
  logic             imem_ready;
  logic             dmem_ready;
  logic             ImemReq;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWriteEn;
  logic             MemReadEn;
  logic             MemWriteEn;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  Op, Funct3, imem_ready, dmem_ready,
    output ImemReq, IRWrite, PCWrite, RegWriteEn, MemReadEn, MemWriteEn,
           state, trap, trap_cause, instret
  );

  modport slave (
    output Op, Funct3, imem_ready, dmem_ready,
    input  ImemReq, IRWrite, PCWrite, RegWriteEn, MemReadEn, MemWriteEn,
           state, trap, trap_cause, instret
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter for memory handshakes; expired flags the last allowed wait cycle.
// expired is combinational from en and the count; counter updates one cycle later.
// Ports: clk/rst, en (waiting with ready low), clr (restart at 0), expired.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_q;

  // The wait that would make the count reach MEM_TIMEOUT is the expiring one.
  assign expired = en && (cnt_q == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 8'd1;   // saturates, never wraps
    end
  end

endmodule

// File: rtl/mc_seq.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer gating PC/IR/regfile/dmem write enables.
// Strobes are decoded from state + latched class (IRWrite / MEM exit also from ready).
// Waits on imem_ready/dmem_ready up to MEM_TIMEOUT cycles, then traps until rst.
// Ports: clk, rst (async, active high), bus (mc_seq_if.master: Op/Funct3/ready in,
// strobes, state, trap, trap_cause, instret out).
module mc_seq
  import mc_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic      clk,
  input  logic      rst,
  mc_seq_if.master  bus
);

  state_t           state_q;
  cls_t             cls_q;
  cause_t           cause_q;
  logic [CNT_W-1:0] instret_q;

  logic tmr_en, tmr_clr, tmr_exp;
  logic imem_req, ir_write, pc_write, reg_write_en, mem_read_en, mem_write_en;
  cls_t id_cls;

  assign id_cls = classify(bus.Op, bus.Funct3);

  // Count only while stalled in a wait state. Every exit from a wait state is
  // either ready (en drops) or expiry, so clearing on !en || expired restarts
  // the counter on every state change.
  assign tmr_en  = ((state_q == S_IF)  && !bus.imem_ready) ||
                   ((state_q == S_MEM) && !bus.dmem_ready);
  assign tmr_clr = !tmr_en || tmr_exp;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en),
    .clr     (tmr_clr),
    .expired (tmr_exp)
  );

  always_comb begin
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        ir_write = bus.imem_ready;
      end
      S_EX:  pc_write = (cls_q == C_BRANCH);
      S_MEM: begin
        mem_read_en  = (cls_q == C_LOAD);
        mem_write_en = (cls_q == C_STORE);
        pc_write     = (cls_q == C_STORE) && bus.dmem_ready;
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      cause_q   <= TC_NONE;
      instret_q <= '0;
    end else begin
      // A PCWrite cycle is a retire cycle; none exist in S_TRAP.
      if (pc_write) instret_q <= instret_q + CNT_W'(1);
      case (state_q)
        S_IDLE: state_q <= S_IF;
        S_IF: begin
          if (bus.imem_ready) begin
            state_q <= S_ID;
          end else if (tmr_exp) begin
            state_q <= S_TRAP;
            cause_q <= TC_IMEM;
          end
        end
        S_ID: begin
          cls_q <= id_cls;
          if (id_cls == C_NONE) begin
            state_q <= S_TRAP;
            cause_q <= TC_ILLEGAL;
          end else begin
            state_q <= S_EX;
          end
        end
        S_EX: begin
          case (cls_q)
            C_BRANCH:       state_q <= S_IF;
            C_LOAD, C_STORE: state_q <= S_MEM;
            default:        state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            state_q <= (cls_q == C_LOAD) ? S_WB : S_IF;
          end else if (tmr_exp) begin
            state_q <= S_TRAP;
            cause_q <= TC_DMEM;
          end
        end
        S_WB:    state_q <= S_IF;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  assign bus.ImemReq    = imem_req;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.RegWriteEn = reg_write_en;
  assign bus.MemReadEn  = mem_read_en;
  assign bus.MemWriteEn = mem_write_en;
  assign bus.state      = state_q;
  assign bus.trap       = (state_q == S_TRAP);
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_mc_seq.sv
// Bench for mc_seq: instruction-level timeline model drives ready handshakes and
// predicts every cycle's state, strobes, trap status and retire count.
// Random legal instruction mix plus directed reset, illegal-opcode and timeout cases.
module tb_mc_seq;

  localparam int TMO = 16;

  logic clk;
  logic rst;

  mc_seq_if #(.CNT_W(32)) bus();

  mc_seq #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec;
  int          n_err;
  logic [31:0] exp_instret;
  logic [1:0]  exp_cause;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Instruction class from the ISA table: 0 illegal, 1 alu, 2 load, 3 store,
  // 4 branch, 5 jal, 6 jalr.
  function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return (f3 == 3'b000) ? 6 : 0;
      default:    return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive ready inputs, check outputs mid-cycle, advance.
  // stb bits: {ImemReq, IRWrite, PCWrite, RegWriteEn, MemReadEn, MemWriteEn}
  task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] stb,
                     input logic ir, input logic dr);
    logic [11:0] e;
    logic [11:0] o;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    #2;
    e = {st, stb, (st == 3'd6), exp_cause};
    o = {bus.state, bus.ImemReq, bus.IRWrite, bus.PCWrite, bus.RegWriteEn,
         bus.MemReadEn, bus.MemWriteEn, bus.trap, bus.trap_cause};
    chk(tag, 32'(o), 32'(e));
    chk({tag, "_instret"}, bus.instret, exp_instret);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_hold(input int n);
    for (int k = 0; k < n; k++) cyc("trap", 3'd6, 6'b000000, rnd(), rnd());
  endtask

  // Asserts rst right now (asynchronously), checks the cleared outputs, then
  // releases it and checks the single idle cycle before fetch.
  task automatic do_reset();
    logic [10:0] o;
    rst = 1'b1;
    #1;
    o = {bus.state, bus.ImemReq, bus.IRWrite, bus.PCWrite, bus.RegWriteEn,
         bus.MemReadEn, bus.MemWriteEn, bus.trap, bus.trap_cause[0]};
    chk("rst_outputs", 32'(o), 32'd0);
    chk("rst_cause", 32'(bus.trap_cause), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = '0;
    exp_cause = 2'b00;
    cyc("idle", 3'd0, 6'b000000, rnd(), rnd());
  endtask

  // Runs one instruction from its first IF cycle. iw/dw are the number of
  // ready-low cycles before imem/dmem ready; >= TMO means ready never comes.
  task automatic exec(input logic [6:0] op, input logic [2:0] f3, input int iw,
                      input int dw, input int tcyc);
    int cls;
    logic [5:0] ms;
    bus.Op = op;
    bus.Funct3 = f3;
    for (int k = 0; k < iw && k < TMO; k++) cyc("if_wait", 3'd1, 6'b100000, 1'b0, rnd());
    if (iw >= TMO) begin
      exp_cause = 2'b10;
      trap_hold(tcyc);
      return;
    end
    cyc("if", 3'd1, 6'b110000, 1'b1, rnd());
    cls = cls_of(op, f3);
    cyc("id", 3'd2, 6'b000000, rnd(), rnd());
    if (cls == 0) begin
      exp_cause = 2'b01;
      trap_hold(tcyc);
      return;
    end
    if (cls == 4) begin
      cyc("ex_branch", 3'd3, 6'b001000, rnd(), rnd());
      exp_instret++;
      return;
    end
    cyc("ex", 3'd3, 6'b000000, rnd(), rnd());
    if (cls == 2 || cls == 3) begin
      ms = (cls == 2) ? 6'b000010 : 6'b000001;
      for (int k = 0; k < dw && k < TMO; k++) cyc("mem_wait", 3'd4, ms, rnd(), 1'b0);
      if (dw >= TMO) begin
        exp_cause = 2'b11;
        trap_hold(tcyc);
        return;
      end
      if (cls == 3) begin
        cyc("mem_store", 3'd4, ms | 6'b001000, rnd(), 1'b1);
        exp_instret++;
        return;
      end
      cyc("mem_load", 3'd4, ms, rnd(), 1'b1);
    end
    cyc("wb", 3'd5, 6'b001100, rnd(), rnd());
    exp_instret++;
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] op;
    logic [2:0] f3;
    int iw, dw;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
    n_vec = 0;
    n_err = 0;
    exp_instret = '0;
    exp_cause = 2'b00;
    rst = 1'b1;
    bus.Op = '0;
    bus.Funct3 = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // ADD with immediate ready, LW with 3 wait cycles, BEQ then SW.
    exec(7'b0110011, 3'b000, 0, 0, 0);
    chk("add_retired", bus.instret, 32'd1);
    exec(7'b0000011, 3'b010, 0, 3, 0);
    exec(7'b1100011, 3'b000, 0, 0, 0);
    exec(7'b0100011, 3'b010, 0, 0, 0);
    chk("beq_sw_retired", bus.instret, 32'd4);

    // Longest waits that still complete.
    exec(7'b1101111, 3'b000, TMO - 1, 0, 0);
    exec(7'b0000011, 3'b000, 0, TMO - 1, 0);

    // Random legal mix with random wait lengths.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      f3 = (op == 7'b1100111) ? 3'b000 : 3'($urandom_range(0, 7));
      iw = $urandom_range(0, 4);
      dw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) iw = TMO - 1;
      if ($urandom_range(0, 9) == 0) dw = TMO - 1;
      exec(op, f3, iw, dw, 0);
    end

    // Reset in the middle of a stalled store.
    bus.Op = 7'b0100011;
    bus.Funct3 = 3'b010;
    cyc("rs_if", 3'd1, 6'b110000, 1'b1, 1'b0);
    cyc("rs_id", 3'd2, 6'b000000, 1'b0, 1'b0);
    cyc("rs_ex", 3'd3, 6'b000000, 1'b0, 1'b0);
    cyc("rs_mem0", 3'd4, 6'b000001, 1'b0, 1'b0);
    cyc("rs_mem1", 3'd4, 6'b000001, 1'b0, 1'b0);
    chk("rs_mwe_before", 32'(bus.MemWriteEn), 32'd1);
    do_reset();

    // Illegal opcodes: trap after ID, held quiet for 50 cycles.
    exec(7'b0010011, 3'b001, 0, 0, 0);
    exec(7'b1111111, 3'b000, 0, 0, 50);
    chk("illegal_instret", bus.instret, 32'd1);
    do_reset();
    exec(7'b1100111, 3'b001, 1, 0, 5);
    do_reset();

    // Instruction fetch timeout, then data timeout on a load.
    exec(7'b0110011, 3'b000, TMO, 0, 8);
    do_reset();
    exec(7'b0110111, 3'b000, 0, 0, 0);
    exec(7'b0000011, 3'b010, 2, TMO, 8);
    chk("dmem_to_instret", bus.instret, 32'd1);
    do_reset();
    exec(7'b0110011, 3'b000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
